sort_job_arbiter: RTL and testbench

Shares one `fsm_sort` instance among `NREQ` requesters. Each requester presents an N-element sort job through a valid/ready handshake. The block picks a winner round-robin, latches its operands, pulses the sorter's start, captures the sorted result and returns it to the owning requester. It sits between the client blocks and the single sorter datapath, and it owns every sorter control input.

---
 rtl/sort_ctrl_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/sort_job_arbiter.sv | 127 ++++++++++++
 tb/tb_sort_job_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_ctrl_pkg.sv
// Shared types and helpers for sorter-sharing controllers.
package sort_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   // Bits needed to count 0 .. timeout-1 (never less than one).
   function automatic int cnt_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, cyclically.
module rr_arbiter #(
   parameter int NREQ  = 3,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [PTR_W-1:0] grant_idx
);

   always_comb begin
      int   idx;
      logic found;
      // NOTE: every output gets a default before the loop, so no path can leave a latch behind.
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PTR_W'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sort_job_arbiter.sv
// Shares one sorter among NREQ requesters: round-robin pick, launch, collect, return result.
module sort_job_arbiter
   import sort_ctrl_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int N       = 6,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*N*WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]           rsp_valid,
   input  logic [NREQ-1:0]           rsp_ready,
   output logic [N*WIDTH-1:0]        rsp_data,
   output logic                      srt_start,
   output logic [N*WIDTH-1:0]        srt_data_in,
   input  logic                      srt_done,
   input  logic [N*WIDTH-1:0]        srt_data_sorted,
   output logic                      busy,
   output logic                      err_timeout
);

   localparam int JOB_W = N * WIDTH;
   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = cnt_width(TIMEOUT);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic [JOB_W-1:0]  opnd_q, opnd_d;
   logic [JOB_W-1:0]  result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [NREQ-1:0]   grant;
   logic [PTR_W-1:0]  grant_idx;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            if (|grant) begin
               opnd_d  = req_data[int'(grant_idx)*JOB_W +: JOB_W];
               owner_d = grant_idx;
               ptr_d   = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            // done beats the terminal count when both land in the same cycle
            if (srt_done) begin
               result_d = srt_data_sorted;
               state_d  = RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready[owner_q]) state_d = IDLE;
         end
      endcase
   end

   // NOTE: flops only take <=; all next-state arithmetic stays in the always_comb above.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         // NOTE: operand/result registers are reset too, so srt_data_in and rsp_data read 0 after rst.
         opnd_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Handshake strobes are masked during rst so nothing is accepted or launched that reset then discards.
   assign req_ready   = (state_q == IDLE && !rst) ? grant : '0;
   assign srt_start   = (state_q == LAUNCH) && !rst;
   assign srt_data_in = opnd_q;
   assign rsp_data    = result_q;
   assign busy        = (state_q != IDLE);
   assign err_timeout = err_q;

   always_comb begin
      rsp_valid = '0;
      if (state_q == RESP && !rst) rsp_valid[owner_q] = 1'b1;
   end

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Directed bench for sort_job_arbiter: a 3-requester instance with a sorter model and a 5-requester wrap instance.
module tb_sort_job_arbiter;

   localparam int N  = 6;
   localparam int WD = 8;
   localparam int JW = N * WD;

   // e0 is the least significant element
   localparam logic [JW-1:0] J0 = {8'd2,   8'd7,  8'd1,   8'd9,  8'd3,  8'd5};
   localparam logic [JW-1:0] S0 = {8'd9,   8'd7,  8'd5,   8'd3,  8'd2,  8'd1};
   localparam logic [JW-1:0] J1 = {8'd16,  8'd4,  8'd255, 8'd0,  8'd8,  8'd8};
   localparam logic [JW-1:0] S1 = {8'd255, 8'd16, 8'd8,   8'd8,  8'd4,  8'd0};
   localparam logic [JW-1:0] J2 = {8'd3,   8'd6,  8'd12,  8'd25, 8'd50, 8'd100};
   localparam logic [JW-1:0] S2 = {8'd100, 8'd50, 8'd25,  8'd12, 8'd6,  8'd3};
   localparam logic [JW-1:0] SB = 48'hABCD_EF01_2345;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]      req_valid, req_ready, rsp_valid, rsp_ready;
   logic [3*JW-1:0] req_data;
   logic [JW-1:0]   rsp_data, srt_data_in;
   logic [JW-1:0]   srt_data_sorted = '0;
   logic            srt_start, srt_done, busy, err_timeout;
   logic            srt_done_m = 1'b0;
   logic            done_force;

   assign srt_done = srt_done_m | done_force;

   sort_job_arbiter #(.NREQ(3), .N(N), .WIDTH(WD), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .srt_start(srt_start), .srt_data_in(srt_data_in),
      .srt_done(srt_done), .srt_data_sorted(srt_data_sorted),
      .busy(busy), .err_timeout(err_timeout)
   );

   logic [4:0]      b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
   logic [5*JW-1:0] b_req_data;
   logic [JW-1:0]   b_rsp_data, b_srt_data_in, b_srt_data_sorted;
   logic            b_srt_start, b_srt_done, b_busy, b_err_timeout;

   sort_job_arbiter #(.NREQ(5), .N(N), .WIDTH(WD), .TIMEOUT(64)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_data(b_req_data),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
      .srt_start(b_srt_start), .srt_data_in(b_srt_data_in),
      .srt_done(b_srt_done), .srt_data_sorted(b_srt_data_sorted),
      .busy(b_busy), .err_timeout(b_err_timeout)
   );

   // Sorter model: rising edge on start, done pulse 6 cycles later unless srt_never is set.
   function automatic logic [JW-1:0] sort6(input logic [JW-1:0] v);
      logic [WD-1:0] e [N];
      logic [WD-1:0] t;
      logic [JW-1:0] r;
      for (int i = 0; i < N; i++) e[i] = v[i*WD +: WD];
      for (int i = 0; i < N - 1; i++)
         for (int j = 0; j < N - 1 - i; j++)
            if (e[j] > e[j+1]) begin
               t = e[j]; e[j] = e[j+1]; e[j+1] = t;
            end
      for (int i = 0; i < N; i++) r[i*WD +: WD] = e[i];
      return r;
   endfunction

   logic start_d   = 1'b0;
   int   srt_cnt   = 0;
   bit   srt_never = 1'b0;

   always @(posedge clk) begin
      start_d    <= srt_start;
      srt_done_m <= 1'b0;
      if (srt_start && !start_d) begin
         srt_cnt <= 6;
      end else if (srt_cnt > 0) begin
         srt_cnt <= srt_cnt - 1;
         if (srt_cnt == 1 && !srt_never) begin
            srt_done_m      <= 1'b1;
            srt_data_sorted <= sort6(srt_data_in);
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input logic [2:0] exp, input string tag);
      int n;
      n = 0;
      #1;
      while (req_ready === 3'b000 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, " grant"}, 64'(req_ready), 64'(exp));
      check({tag, " start low before launch"}, 64'(srt_start), 64'd0);
   endtask

   // Entered on the negedge where the grant is visible; returns in RESP after checking the result.
   task automatic serve_a(input int r, input logic [JW-1:0] job, input logic [JW-1:0] exp,
                          input bit drop, input string tag);
      int n;
      @(negedge clk);
      if (drop) req_valid[r] = 1'b0;
      check({tag, " start"}, 64'(srt_start), 64'd1);
      check({tag, " ready low in launch"}, 64'(req_ready), 64'd0);
      @(negedge clk);
      check({tag, " start one cycle"}, 64'(srt_start), 64'd0);
      check({tag, " operands"}, 64'(srt_data_in), 64'(job));
      n = 0;
      while (srt_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, " done seen"}, 64'(srt_done), 64'd1);
      check({tag, " no rsp yet"}, 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1) << r);
      check({tag, " rsp_data"}, 64'(rsp_data), 64'(exp));
   endtask

   task automatic rsp_take(input int r, input string tag);
      rsp_ready[r] = 1'b1;
      @(negedge clk);
      rsp_ready = '0;
      check({tag, " rsp dropped"}, 64'(rsp_valid), 64'd0);
   endtask

   task automatic b_serve(input int r, input string tag);
      @(negedge clk);
      b_req_valid[r] = 1'b0;
      check({tag, " start"}, 64'(b_srt_start), 64'd1);
      @(negedge clk);
      check({tag, " operands"}, 64'(b_srt_data_in), 64'(r + 1));
      b_srt_done        = 1'b1;
      b_srt_data_sorted = SB;
      @(negedge clk);
      b_srt_done = 1'b0;
      check({tag, " rsp_valid"}, 64'(b_rsp_valid), 64'(1) << r);
      check({tag, " rsp_data"}, 64'(b_rsp_data), 64'(SB));
      b_rsp_ready[r] = 1'b1;
      @(negedge clk);
      b_rsp_ready = '0;
      check({tag, " rsp dropped"}, 64'(b_rsp_valid), 64'd0);
   endtask

   initial begin
      logic [JW-1:0] jobs [3];
      logic [JW-1:0] sorts [3];
      int  w;
      bit  saw;

      jobs[0] = J1; sorts[0] = S1;
      jobs[1] = J0; sorts[1] = S0;
      jobs[2] = J2; sorts[2] = S2;

      req_valid  = '0;
      rsp_ready  = '0;
      done_force = 1'b0;
      req_data   = {J2, J0, J1};
      b_req_valid = '0;
      b_rsp_ready = '0;
      b_srt_done  = 1'b0;
      b_srt_data_sorted = '0;
      for (int r = 0; r < 5; r++) b_req_data[r*JW +: JW] = JW'(r + 1);

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst req_ready", 64'(req_ready), 64'd0);
      check("rst rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst srt_start", 64'(srt_start), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst err_timeout", 64'(err_timeout), 64'd0);
      check("rst srt_data_in", 64'(srt_data_in), 64'd0);
      check("rst rsp_data", 64'(rsp_data), 64'd0);

      // Single job from r1
      req_valid = 3'b010;
      wait_grant(3'b010, "t1");
      check("t1 busy idle", 64'(busy), 64'd0);
      serve_a(1, J0, S0, 1'b1, "t1");
      check("t1 busy resp", 64'(busy), 64'd1);
      rsp_take(1, "t1");
      check("t1 busy after", 64'(busy), 64'd0);

      // ptr is now 2: r0 and r2 both valid, r2 must win
      req_valid = 3'b101;
      wait_grant(3'b100, "ptr2");
      serve_a(2, J2, S2, 1'b1, "t3a");
      rsp_take(2, "t3a");
      wait_grant(3'b001, "t3b");
      serve_a(0, J1, S1, 1'b1, "t3b");

      // r0 stalls its response for 10 cycles; other rsp_ready bits must be ignored
      req_valid[2] = 1'b1;
      rsp_ready    = 3'b110;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold rsp_valid", 64'(rsp_valid), 64'd1);
         check("hold rsp_data", 64'(rsp_data), 64'(S1));
         check("hold req_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 3'b001;
      @(negedge clk);
      rsp_ready = '0;
      #1;
      check("t3 rsp dropped", 64'(rsp_valid), 64'd0);
      check("t3 r2 granted next cycle", 64'(req_ready), 64'd4);
      serve_a(2, J2, S2, 1'b1, "t3c");
      rsp_take(2, "t3c");

      // All three valid straight out of reset: grant order 0,1,2,0,1,2
      req_valid = 3'b111;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst masks req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         w = k % 3;
         wait_grant(3'(1 << w), "rr");
         serve_a(w, jobs[w], sorts[w], 1'b0, "rr");
         rsp_take(w, "rr");
      end
      req_valid = '0;

      // Sorter never finishes: timeout, then a normal job
      srt_never = 1'b1;
      req_valid = 3'b001;
      wait_grant(3'b001, "to");
      @(negedge clk);
      req_valid = '0;
      check("to start", 64'(srt_start), 64'd1);
      saw = 1'b0;
      for (int i = 0; i < 63; i++) begin
         @(negedge clk);
         if (rsp_valid !== 3'b000) saw = 1'b1;
      end
      @(negedge clk);
      check("to err before", 64'(err_timeout), 64'd0);
      check("to busy before", 64'(busy), 64'd1);
      @(negedge clk);
      check("to err set", 64'(err_timeout), 64'd1);
      check("to idle", 64'(busy), 64'd0);
      check("to no rsp", 64'(rsp_valid | 3'(saw)), 64'd0);
      srt_never = 1'b0;
      req_valid = 3'b010;
      wait_grant(3'b010, "to2");
      serve_a(1, J0, S0, 1'b1, "to2");
      check("to2 err sticky", 64'(err_timeout), 64'd1);
      rsp_take(1, "to2");

      // Reset during RUN, then a stale done
      req_valid = 3'b100;
      wait_grant(3'b100, "mr");
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      check("mr busy in run", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mr req_ready", 64'(req_ready), 64'd0);
      check("mr rsp_valid", 64'(rsp_valid), 64'd0);
      check("mr srt_start", 64'(srt_start), 64'd0);
      check("mr busy", 64'(busy), 64'd0);
      check("mr err cleared", 64'(err_timeout), 64'd0);
      check("mr srt_data_in", 64'(srt_data_in), 64'd0);
      check("mr rsp_data", 64'(rsp_data), 64'd0);
      repeat (2) @(negedge clk);
      done_force = 1'b1;
      @(negedge clk);
      done_force = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 3'b000 || busy !== 1'b0) saw = 1'b1;
      end
      check("mr stale done ignored", 64'(saw), 64'd0);
      req_valid = 3'b101;
      wait_grant(3'b001, "mr ptr0");
      serve_a(0, J1, S1, 1'b1, "mr");
      req_valid = '0;
      rsp_take(0, "mr");

      // Five requesters: move ptr to 4, then r4 and r0 valid -> r4, r0 (wrap), ptr=1
      b_req_valid = 5'b01000;
      #1;
      check("b grant r3", 64'(b_req_ready), 64'h08);
      b_serve(3, "b r3");
      b_req_valid = 5'b10001;
      #1;
      check("b grant r4", 64'(b_req_ready), 64'h10);
      b_serve(4, "b r4");
      #1;
      check("b grant r0 wrap", 64'(b_req_ready), 64'h01);
      b_serve(0, "b r0");
      b_req_valid = 5'b10001;
      #1;
      check("b ptr1", 64'(b_req_ready), 64'h10);
      b_req_valid = '0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
